gf_vme_access_initiator: RTL
============================

// Module: gf_vme_access_initiator
// PURPOSE
//  Initiator end of the internal VME register-access interface. It turns a one-cycle
//  request into a level access: address/wdata stable, then writeAccess or readAccess
//  held high until acknowledged. The target's per-register pulse decoders sit on the
//  other end. Used by on-board sequencers and test logic to run register cycles
//  without the VME bus.
// PARAMETERS
//  ADDR_W          16   access address width
//  DATA_W          32   write/read data width
//  HOLD_MIN        2    min cycles access level stays high (>=1)
//  GAP_CYCLES      2    idle cycles after release before next request (>=1)
//  TIMEOUT_CYCLES  255  STROBE cycles without ack before abort (only with timeout)
// PORTS
//  clk          in   1       system clock
//  init         in   1       synchronous active-high reset
//  reqStart     in   1       request pulse; sampled only when busy=0
//  reqWrite     in   1       1=write, 0=read; qualified by reqStart
//  reqAddress   in   ADDR_W  target address; qualified by reqStart
//  reqWdata     in   DATA_W  write data; qualified by reqStart
//  busy         out  1       high from accept cycle+1 until back in IDLE
//  done         out  1       1-cycle pulse: access finished
//  error        out  1       1-cycle pulse with done: access timed out
//  rdata        out  DATA_W  read data; valid from done, held until next done
//  address      out  ADDR_W  access address to targets
//  wdata        out  DATA_W  write data to targets
//  writeAccess  out  1       write access level
//  readAccess   out  1       read access level
//  accessAck    in   1       target acknowledge; level or pulse
//  accessRdata  in   DATA_W  target read data; valid when accessAck=1
// BEHAVIOUR
//  - All outputs are registered. init (sync, high) forces at the next edge: IDLE,
//    busy/done/error/writeAccess/readAccess=0, address/wdata/rdata=0, counters=0.
//    A reset mid-access drops the access level immediately, with no done pulse.
//  - FSM: IDLE -> SETUP -> STROBE -> RELEASE -> GAP -> IDLE.
//  - IDLE: reqStart=1 latches reqWrite/reqAddress/reqWdata and goes to SETUP.
//    reqStart while busy=1 is ignored, not queued.
//  - SETUP (1 cycle): address/wdata driven; both access levels stay 0.
//  - STROBE: writeAccess (write) or readAccess (read) = 1. Never both.
//    - holdCnt counts STROBE cycles. Any accessAck=1 during STROBE sets ackSeen.
//    - The first ack cycle also captures accessRdata (read only).
//    - Exit when ackSeen (including the current cycle's ack) and holdCnt >= HOLD_MIN.
//  - RELEASE (1 cycle): access levels 0, address/wdata still held.
//  - GAP: GAP_CYCLES cycles with busy=1 and access levels 0. done=1 in the first GAP
//    cycle. Then IDLE.
//  - accessAck outside STROBE is ignored.
//  - Writes leave rdata unchanged.
//  - Latency, defaults, ack in the first STROBE cycle:
//    - accept edge E0; SETUP in cycle 1; access high in cycles 2-3; RELEASE in 4;
//    - done in 5; busy=0 from 7, so a new reqStart can be accepted in 7.
//  - Counters saturate. No wrap-around. Widths are $clog2(param+1).
// CONFIGURATION
//  GF_VME_INIT_TIMEOUT_EN defined:
//    - toCnt counts STROBE cycles. After TIMEOUT_CYCLES cycles with no ack, go to
//      RELEASE, then error=1 and done=1 together.
//    - On a timed-out read, rdata = all ones.
//    - If ack and timeout hit in the same cycle, ack wins (no error).
//  Not defined:
//    - STROBE waits forever for ack.
//    - error is tied to 0 and toCnt is not built.
// STRUCTURE
//  Package gf_vme_pkg:
//    - FSM state enum (3-bit): IDLE=0, SETUP=1, STROBE=2, RELEASE=3, GAP=4.
//    - GF_VME_RDATA_ERR fill constant (all ones).
//  Sub-module gf_vme_cycle_counter (clear / enable / saturate / terminal-count flag).
//  One instance each for holdCnt, the gap counter and toCnt (toCnt only with the macro).
//  FSM and data registers are in the top level.
// TESTING
//  1 write 0x1234<-0xDEADBEEF, ack in the 1st STROBE cycle:
//    -> writeAccess high exactly 2 cycles; address stable from SETUP to RELEASE;
//    -> done at cycle 5; busy for 6 cycles.
//  2 read 0x0040, ack pulse on STROBE cycle 4 with accessRdata=0xCAFE0001:
//    -> readAccess high 4 cycles; rdata=0xCAFE0001 at done; writeAccess never high.
//  3 reqStart held high continuously:
//    -> back-to-back accesses; access level 0 for >= GAP_CYCLES+1 cycles between
//       them; no request lost or duplicated.
//  4 init asserted in the 2nd STROBE cycle:
//    -> next cycle all outputs 0, FSM IDLE, no done pulse;
//    -> the next request runs normally.
//  5 macro on, TIMEOUT_CYCLES=8, read with no ack:
//    -> done=error=1 after 8 STROBE cycles; rdata=0xFFFFFFFF.
//    -> Repeat with ack on cycle 8: error=0.
//  6 accessAck pulsed during IDLE/SETUP/GAP:
//    -> ignored; the following access still waits for its own ack.

Source files
------------

// File: rtl/gf_vme_pkg.sv
// Shared types and constants for the internal VME register-access initiator.
package gf_vme_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        RELEASE = 3'd3,
        GAP     = 3'd4
    } vmeState_t;

    // Read data reported for an access that was abandoned without an acknowledge
    localparam logic [63:0] GF_VME_RDATA_ERR = '1;

endpackage

// File: rtl/gf_vme_cycle_counter.sv
// Saturating cycle counter with clear/enable; lastCycle flags the MAX-th enabled cycle.
module gf_vme_cycle_counter #(
    parameter int MAX = 2
) (
    input  logic clk,
    input  logic init,
    input  logic clear,
    input  logic enable,
    output logic lastCycle
);

    localparam int W = (MAX > 0) ? $clog2(MAX + 1) : 1;
    localparam logic [W-1:0] TOP  = W'(MAX);
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (init || clear) begin
            count <= '0;
        end else if (enable && (count != TOP)) begin
            count <= count + 1'b1;
        end
    end

    // count holds completed cycles, so the current enabled cycle is number count+1
    assign lastCycle = enable && (count >= LAST);

endmodule

// File: rtl/gf_vme_access_initiator.sv
// Initiator end of the internal VME register-access interface (request pulse -> access level).
// Optional strobe timeout enabled by defining GF_VME_INIT_TIMEOUT_EN.
module gf_vme_access_initiator
    import gf_vme_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int HOLD_MIN       = 2,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              init,
    input  logic              reqStart,
    input  logic              reqWrite,
    input  logic [ADDR_W-1:0] reqAddress,
    input  logic [DATA_W-1:0] reqWdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] wdata,
    output logic              writeAccess,
    output logic              readAccess,
    input  logic              accessAck,
    input  logic [DATA_W-1:0] accessRdata
);

    if (HOLD_MIN < 1 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : gBadParams
        $error("gf_vme_access_initiator: HOLD_MIN, GAP_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    vmeState_t         state;
    vmeState_t         nextState;
    logic              isWrite;
    logic              ackSeen;
    logic              ackNow;
    logic              holdLast;
    logic              gapLast;
    logic              timeoutHit;
    logic              timedOut;
    logic [DATA_W-1:0] rdataCap;

    assign ackNow = (state == STROBE) && (ackSeen || accessAck);

    gf_vme_cycle_counter #(.MAX(HOLD_MIN)) uHoldCnt (
        .clk       (clk),
        .init      (init),
        .clear     (state != STROBE),
        .enable    (state == STROBE),
        .lastCycle (holdLast)
    );

    gf_vme_cycle_counter #(.MAX(GAP_CYCLES)) uGapCnt (
        .clk       (clk),
        .init      (init),
        .clear     (state != GAP),
        .enable    (state == GAP),
        .lastCycle (gapLast)
    );

`ifdef GF_VME_INIT_TIMEOUT_EN
    logic toLast;

    gf_vme_cycle_counter #(.MAX(TIMEOUT_CYCLES)) uToCnt (
        .clk       (clk),
        .init      (init),
        .clear     (state != STROBE),
        .enable    (state == STROBE),
        .lastCycle (toLast)
    );

    // An acknowledge arriving in the final allowed cycle still completes the access
    assign timeoutHit = toLast && !ackNow;

    always_ff @(posedge clk) begin
        if (init) begin
            timedOut <= 1'b0;
            error    <= 1'b0;
        end else begin
            if (state == SETUP) begin
                timedOut <= 1'b0;
            end else if ((state == STROBE) && timeoutHit) begin
                timedOut <= 1'b1;
            end
            error <= (state == RELEASE) && timedOut;
        end
    end
`else
    assign timeoutHit = 1'b0;
    assign timedOut   = 1'b0;
    assign error      = 1'b0;
`endif

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (reqStart) nextState = SETUP;
            SETUP:   nextState = STROBE;
            STROBE:  if ((ackNow && holdLast) || timeoutHit) nextState = RELEASE;
            RELEASE: nextState = GAP;
            GAP:     if (gapLast) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (init) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            writeAccess <= 1'b0;
            readAccess  <= 1'b0;
            address     <= '0;
            wdata       <= '0;
            rdata       <= '0;
            isWrite     <= 1'b0;
            ackSeen     <= 1'b0;
            rdataCap    <= '0;
        end else begin
            state       <= nextState;
            busy        <= (nextState != IDLE);
            done        <= (state == RELEASE);
            writeAccess <= (nextState == STROBE) && isWrite;
            readAccess  <= (nextState == STROBE) && !isWrite;
            ackSeen     <= ackNow;
            if ((state == IDLE) && reqStart) begin
                isWrite <= reqWrite;
                address <= reqAddress;
                wdata   <= reqWdata;
            end
            if ((state == STROBE) && accessAck && !ackSeen && !isWrite) begin
                rdataCap <= accessRdata;
            end
            if ((state == RELEASE) && !isWrite) begin
                rdata <= timedOut ? GF_VME_RDATA_ERR[DATA_W-1:0] : rdataCap;
            end
        end
    end

endmodule
